aes_result_reader: RTL and testbench

Drain-side companion to the five-lane AES encryption top: captures each lane's 128-bit ciphertext from the packed 640-bit result bus when that lane signals completion, then streams the buffered blocks out as 32-bit words over a valid/ready interface toward the host/DMA path on the Zed board. It holds one block per lane and arbitrates round-robin between lanes with pending data. Lost blocks are flagged per lane.

---
 rtl/aes_result_reader_if.sv | 21 ++
 rtl/aes_result_reader.sv | 149 ++++++++++++++
 tb/tb_aes_result_reader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_result_reader_if.sv
// Word-stream bus carrying buffered AES ciphertext blocks from the reader to the host/DMA sink.
interface aes_result_reader_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LANE_W = 3
);
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [LANE_W-1:0] out_lane;

  modport master (
    output out_data, out_valid, out_last, out_lane,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_last, out_lane,
    output out_ready
  );
endinterface

// File: rtl/aes_result_reader.sv
// Buffers one ciphertext block per AES lane and drains them round-robin as MSB-first
// words over a valid/ready stream; lost blocks are flagged per lane in a sticky overrun.
module aes_result_reader #(
  parameter int unsigned LANES   = 5,
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned WORD_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES*BLOCK_W-1:0] enc_in,
  input  logic [LANES-1:0]         lane_done,
  aes_result_reader_if.master      out_if,
  output logic [LANES-1:0]         overrun,
  input  logic                     overrun_clr,
  output logic                     busy
);

  localparam int unsigned WORDS  = BLOCK_W / WORD_W;
  localparam int unsigned WIDX_W = $clog2(WORDS);
  localparam int unsigned LANE_W = 3;

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   sel_q, sel_d;
  logic [LANE_W-1:0]   last_served_q, last_served_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [LANES-1:0]    pending_q, pending_d;
  logic [LANES-1:0]    overrun_q, overrun_d;
  logic [LANES-1:0]    capture;
  logic [BLOCK_W-1:0]  blk_q [LANES];

  logic                hs, fin;
  logic                rr_found;
  logic [LANE_W-1:0]   rr_sel;
  int unsigned         rr_idx;
  logic [BLOCK_W-1:0]  cur_blk;
  logic [WORD_W-1:0]   cur_word;

  always_comb begin
    hs  = (state_q == SEND) && out_if.out_ready;
    fin = hs && (word_idx_q == WIDX_W'(WORDS - 1));
  end

  // Round-robin: first pending lane strictly after last_served, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = 0;
    for (int unsigned k = 1; k <= LANES; k++) begin
      rr_idx = (32'(last_served_q) + k) % LANES;
      for (int unsigned i = 0; i < LANES; i++) begin
        if (!rr_found && (rr_idx == i) && pending_q[i]) begin
          rr_found = 1'b1;
          rr_sel   = LANE_W'(i);
        end
      end
    end
  end

  always_comb begin
    cur_blk = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (sel_q == LANE_W'(i)) cur_blk = blk_q[i];
    end
    cur_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (word_idx_q == WIDX_W'(w)) cur_word = cur_blk[BLOCK_W-1-w*WORD_W -: WORD_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    word_idx_d    = word_idx_q;
    last_served_d = last_served_q;
    pending_d     = pending_q;
    overrun_d     = overrun_clr ? '0 : overrun_q;
    capture       = '0;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          sel_d      = rr_sel;
          word_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          word_idx_d = word_idx_q + WIDX_W'(1);
          if (fin) begin
            pending_d[sel_q] = 1'b0;
            last_served_d    = sel_q;
            state_d          = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The final-word release is applied first so a coincident lane_done for the
    // lane just drained is accepted as a fresh capture rather than an overrun.
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_done[i]) begin
        if (pending_d[i]) begin
          overrun_d[i] = 1'b1;
        end else begin
          capture[i]   = 1'b1;
          pending_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      word_idx_q    <= '0;
      last_served_q <= LANE_W'(LANES - 1);
      pending_q     <= '0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      word_idx_q    <= word_idx_d;
      last_served_q <= last_served_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (capture[i]) blk_q[i] <= enc_in[i*BLOCK_W +: BLOCK_W];
    end
  end

  always_comb begin
    out_if.out_valid = (state_q == SEND);
    out_if.out_data  = (state_q == SEND) ? cur_word : '0;
    out_if.out_last  = (state_q == SEND) && (word_idx_q == WIDX_W'(WORDS - 1));
    out_if.out_lane  = sel_q;
    overrun          = overrun_q;
    busy             = (|pending_q) || (state_q != IDLE);
  end

endmodule

// File: tb/tb_aes_result_reader.sv
// Directed bench for aes_result_reader: table of expected output words plus hand sequences.
module tb_aes_result_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic [639:0] enc_in;
  logic [4:0]   lane_done;
  logic [4:0]   overrun;
  logic         overrun_clr;
  logic         busy;

  aes_result_reader_if #(.WORD_W(32), .LANE_W(3)) bus ();

  aes_result_reader #(.LANES(5), .BLOCK_W(128), .WORD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .enc_in      (enc_in),
    .lane_done   (lane_done),
    .out_if      (bus),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  lane;
    logic        last;
  } vec_t;

  vec_t vecs[36];
  int   checks = 0;
  int   errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [127:0] d);
    enc_in[l*128 +: 128] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    lane_done = '0;
    overrun_clr = 1'b0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Collect n handshaken words with ready held high, comparing against vecs[first..].
  // When inj_at >= 0, lane_done/inj_data are driven in the cycle of that word's handshake.
  task automatic drain(input int first, input int n, input int inj_at,
                       input logic [4:0] inj_mask, input logic [127:0] inj_data,
                       output int got, output int span);
    int cyc = 0;
    int fc = 0;
    int lc = 0;
    got = 0;
    bus.out_ready = 1'b1;
    while (got < n && cyc < 200) begin
      if (bus.out_valid && bus.out_ready) begin
        if (got == inj_at) begin
          for (int l = 0; l < 5; l++) if (inj_mask[l]) set_lane(l, inj_data);
          lane_done = inj_mask;
        end
        chk($sformatf("word%0d", first + got),
            {bus.out_lane, bus.out_last, bus.out_data},
            {vecs[first+got].lane, vecs[first+got].last, vecs[first+got].data});
        if (got == 0) fc = cyc;
        lc = cyc;
        got++;
      end
      tick;
      lane_done = '0;
      cyc++;
    end
    span = lc - fc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lw [5];
    logic [7:0]  lb;
    logic [31:0] bpw [4];
    int          pat [8];
    int          got, span, k, saw;

    rst = 1'b1;
    enc_in = '0;
    lane_done = '0;
    overrun_clr = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0]  = '{32'h69c4e0d8, 3'd0, 1'b0};
    vecs[1]  = '{32'h6a7b0430, 3'd0, 1'b0};
    vecs[2]  = '{32'hd8cdb780, 3'd0, 1'b0};
    vecs[3]  = '{32'h70b4c55a, 3'd0, 1'b1};
    lw = '{32'h10101010, 32'h11111111, 32'h12121212, 32'h13131313, 32'h14141414};
    for (int l = 0; l < 5; l++)
      for (int w = 0; w < 4; w++)
        vecs[4+4*l+w] = '{lw[l], 3'(l), (w == 3)};
    vecs[24] = '{32'hdeadbeef, 3'd2, 1'b0};
    vecs[25] = '{32'hcafef00d, 3'd2, 1'b0};
    vecs[26] = '{32'h01234567, 3'd2, 1'b0};
    vecs[27] = '{32'h89abcdef, 3'd2, 1'b1};
    vecs[28] = '{32'h3243f6a8, 3'd3, 1'b0};
    vecs[29] = '{32'h885a308d, 3'd3, 1'b0};
    vecs[30] = '{32'h313198a2, 3'd3, 1'b0};
    vecs[31] = '{32'he0370734, 3'd3, 1'b1};
    vecs[32] = '{32'h2b7e1516, 3'd3, 1'b0};
    vecs[33] = '{32'h28aed2a6, 3'd3, 1'b0};
    vecs[34] = '{32'habf71588, 3'd3, 1'b0};
    vecs[35] = '{32'h09cf4f3c, 3'd3, 1'b1};

    // Reset values
    do_reset;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_last", bus.out_last, 1'b0);
    chk("rst_data", bus.out_data, 32'h0);
    chk("rst_lane", bus.out_lane, 3'd0);
    chk("rst_overrun", overrun, 5'b00000);
    chk("rst_busy", busy, 1'b0);

    // Single block, cycle-exact latency
    bus.out_ready = 1'b1;
    set_lane(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    lane_done = 5'b00001;
    tick;
    lane_done = '0;
    chk("single_busy_n1", busy, 1'b1);
    chk("single_valid_n1", bus.out_valid, 1'b0);
    tick;
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("single_valid_w%0d", w), bus.out_valid, 1'b1);
      chk($sformatf("single_word%0d", w), {bus.out_lane, bus.out_last, bus.out_data},
          {vecs[w].lane, vecs[w].last, vecs[w].data});
      tick;
    end
    chk("single_idle_valid", bus.out_valid, 1'b0);
    chk("single_idle_busy", busy, 1'b0);

    // All lanes at once, order 0..4 from reset, 4 words per 5 cycles
    do_reset;
    for (int l = 0; l < 5; l++) begin
      lb = 8'h10 + 8'(l);
      set_lane(l, {16{lb}});
    end
    lane_done = 5'b11111;
    tick;
    lane_done = '0;
    drain(4, 20, -1, 5'b0, 128'h0, got, span);
    chk("all_count", got, 20);
    chk("all_span", span, 23);
    chk("all_busy_end", busy, 1'b0);

    // Back-pressure
    do_reset;
    set_lane(1, 128'h00112233445566778899aabbccddeeff);
    bpw = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    pat = '{1, 0, 0, 1, 0, 1, 1, 0};
    lane_done = 5'b00010;
    tick;
    lane_done = '0;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      bus.out_ready = (pat[cyc % 8] != 0);
      if (bus.out_valid) begin
        chk($sformatf("bp_word%0d_c%0d", k, cyc), {bus.out_lane, bus.out_last, bus.out_data},
            {3'd1, (k == 3), bpw[k]});
        if (bus.out_ready) k++;
      end
      tick;
    end
    chk("bp_count", k, 4);
    chk("bp_valid_end", bus.out_valid, 1'b0);

    // Overrun: second pulse dropped, sticky flag, clear, clear+event collision
    do_reset;
    set_lane(2, 128'hdeadbeefcafef00d0123456789abcdef);
    lane_done = 5'b00100;
    tick;
    set_lane(2, 128'h55555555666666667777777788888888);
    lane_done = 5'b00100;
    tick;
    lane_done = '0;
    chk("ovr_set", overrun, 5'b00100);
    drain(24, 4, -1, 5'b0, 128'h0, got, span);
    chk("ovr_count", got, 4);
    chk("ovr_sticky", overrun, 5'b00100);
    chk("ovr_busy_end", busy, 1'b0);
    overrun_clr = 1'b1;
    tick;
    overrun_clr = 1'b0;
    chk("ovr_clear", overrun, 5'b00000);
    bus.out_ready = 1'b0;
    lane_done = 5'b10000;
    tick;
    lane_done = 5'b10000;
    overrun_clr = 1'b1;
    tick;
    lane_done = '0;
    overrun_clr = 1'b0;
    chk("ovr_clr_collide", overrun, 5'b10000);

    // Final-word collision on lane 3
    do_reset;
    set_lane(3, 128'h3243f6a8885a308d313198a2e0370734);
    lane_done = 5'b01000;
    tick;
    lane_done = '0;
    drain(28, 8, 3, 5'b01000, 128'h2b7e151628aed2a6abf7158809cf4f3c, got, span);
    chk("coll_count", got, 8);
    chk("coll_span", span, 8);
    chk("coll_overrun", overrun, 5'b00000);
    chk("coll_busy_end", busy, 1'b0);

    // Reset mid-block after word 1
    do_reset;
    bus.out_ready = 1'b1;
    set_lane(0, 128'hdeadbeefcafef00d0123456789abcdef);
    set_lane(1, 128'h00112233445566778899aabbccddeeff);
    lane_done = 5'b00011;
    tick;
    lane_done = 5'b00010;
    tick;
    lane_done = '0;
    chk("mid_word0", bus.out_data, 32'hdeadbeef);
    tick;
    chk("mid_word1", bus.out_data, 32'hcafef00d);
    chk("mid_overrun_pre", overrun, 5'b00010);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_valid", bus.out_valid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_overrun", overrun, 5'b00000);
    saw = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) saw++;
      tick;
    end
    chk("mid_no_replay", saw, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
